// File: rtl/hist_pass_scheduler_if.sv
// ============================================================================
// Module   : hist_pass_scheduler_if
// Brief    : Sample stream, builder write port and clear/peak handshakes.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hist_pass_scheduler_if #(
    parameter int NP = 12
);
    logic          s_valid;
    logic [NP-1:0] s_data;
    logic          s_ready;
    logic          clr_req;
    logic          clr_done;
    logic          wr_en;
    logic [NP-1:0] wr_data;
    logic [7:0]    wr_pixel;
    logic          peak_req;
    logic          peak_done;

    // Scheduler side
    modport master (
        input  s_valid, s_data, clr_done, peak_done,
        output s_ready, clr_req, wr_en, wr_data, wr_pixel, peak_req
    );

    // Sample source, RAM clear engine, builder and peak unit side
    modport slave (
        output s_valid, s_data, clr_done, peak_done,
        input  s_ready, clr_req, wr_en, wr_data, wr_pixel, peak_req
    );
endinterface

`default_nettype wire

// File: rtl/hist_pass_scheduler.sv
// ============================================================================
// Module   : hist_pass_scheduler
// Brief    : Sequences a coarse and a fine histogram pass per frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hist_pass_scheduler #(
    parameter int DATA_NUM  = 4,
    parameter int PIXEL_NUM = 200,
    parameter int ACQ_NUM   = 33333,
    parameter int NP        = 12
) (
    input  wire logic              clk,
    input  wire logic              res,
    input  wire logic              start,
    input  wire logic              abort,
    hist_pass_scheduler_if.master  bus,
    output logic                   pass,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int DW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam logic [DW-1:0] DATA_LAST = DW'(DATA_NUM - 1);
    localparam logic [7:0]    PIX_LAST  = 8'(PIXEL_NUM - 1);
    localparam logic [19:0]   ACQ_LAST  = 20'(ACQ_NUM - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR_C  = 3'd1,
        COARSE = 3'd2,
        PEAK_C = 3'd3,
        CLR_F  = 3'd4,
        FINE   = 3'd5,
        PEAK_F = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          pass_next;
    logic [DW-1:0] data_cnt;
    logic [7:0]    pix_cnt;
    logic [19:0]   acq_cnt;
    logic          accept;
    logic          data_wrap;
    logic          pix_wrap;
    logic          acq_wrap;
    logic          last_sample;

    // Abort also closes the handshake so the source never sees a lost sample.
    assign bus.s_ready = ((state == COARSE) || (state == FINE)) && !abort;
    assign accept      = bus.s_valid && bus.s_ready;
    assign data_wrap   = (data_cnt == DATA_LAST);
    assign pix_wrap    = (pix_cnt == PIX_LAST);
    assign acq_wrap    = (acq_cnt == ACQ_LAST);
    assign last_sample = accept && data_wrap && pix_wrap && acq_wrap;

    always_comb begin
        state_next     = state;
        pass_next      = pass;
        bus.clr_req    = 1'b0;
        bus.peak_req   = 1'b0;
        busy           = (state != IDLE);
        frame_done     = 1'b0;

        if (abort && (state != IDLE)) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)         state_next = CLR_C;
                CLR_C:   if (bus.clr_done)  state_next = COARSE;
                COARSE:  if (last_sample)   state_next = PEAK_C;
                PEAK_C:  if (bus.peak_done) state_next = CLR_F;
                CLR_F:   if (bus.clr_done)  state_next = FINE;
                FINE:    if (last_sample)   state_next = PEAK_F;
                PEAK_F:  if (bus.peak_done) state_next = DONE;
                DONE:                       state_next = IDLE;
                default:                    state_next = IDLE;
            endcase
        end

        case (state_next)
            CLR_C, COARSE, PEAK_C:      pass_next = 1'b0;
            CLR_F, FINE, PEAK_F, DONE:  pass_next = 1'b1;
            default:                    pass_next = pass;
        endcase

        case (state)
            CLR_C, CLR_F:   bus.clr_req  = 1'b1;
            PEAK_C, PEAK_F: bus.peak_req = 1'b1;
            DONE:           frame_done   = !abort;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            pass  <= 1'b0;
        end else begin
            state <= state_next;
            pass  <= pass_next;
        end
    end

    // Counters are mixed-radix: data within pixel within acquisition.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            data_cnt <= '0;
            pix_cnt  <= '0;
            acq_cnt  <= '0;
        end else if (abort) begin
            data_cnt <= '0;
            pix_cnt  <= '0;
            acq_cnt  <= '0;
        end else if (accept) begin
            if (data_wrap) begin
                data_cnt <= '0;
                if (pix_wrap) begin
                    pix_cnt <= '0;
                    acq_cnt <= acq_wrap ? 20'd0 : acq_cnt + 20'd1;
                end else begin
                    pix_cnt <= pix_cnt + 8'd1;
                end
            end else begin
                data_cnt <= data_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            bus.wr_en    <= 1'b0;
            bus.wr_data  <= '0;
            bus.wr_pixel <= '0;
        end else begin
            bus.wr_en <= accept;
            if (accept) begin
                bus.wr_data  <= bus.s_data;
                bus.wr_pixel <= pix_cnt;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/hist_pass_scheduler.md
HIST_PASS_SCHEDULER -- requirements
Module: hist_pass_scheduler

Interface
REQ-001 Parameter DATA_NUM, 4, samples per pixel per acquisition.
REQ-002 Parameter PIXEL_NUM, 200, pixels per RAM.
REQ-003 Parameter ACQ_NUM, 33333, acquisitions per pass.
REQ-004 Parameter NP, 12, sample width.
REQ-005 Ports SHALL be:
- clk  in  1  single clock
- res  in  1  reset, asynchronous, active-high
- start  in  1  frame start pulse
- abort  in  1  synchronous abort
- s_valid  in  1  TDC sample valid
- s_data  in  NP  TDC sample
- s_ready  out  1  sample accepted when s_valid&&s_ready
- clr_req  out  1  histogram RAM clear request
- clr_done  in  1  clear complete pulse
- wr_en  out  1  builder write strobe
- wr_data  out  NP  registered sample
- wr_pixel  out  8  pixel index of wr_data
- pass  out  1  0 = coarse, 1 = fine
- peak_req  out  1  peak/threshold update request
- peak_done  in  1  peak update complete pulse
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle end-of-frame pulse

Function
REQ-006 States SHALL be IDLE, CLR_C, COARSE, PEAK_C, CLR_F, FINE, PEAK_F, DONE.
REQ-007 IDLE->CLR_C on start; start outside IDLE SHALL be ignored.
REQ-008 clr_req SHALL be high throughout CLR_C/CLR_F; on clr_done, CLR_C->COARSE, CLR_F->FINE.
REQ-009 s_ready SHALL be 1 only in COARSE/FINE and when the pass sample count is not exhausted.
REQ-010 Each accepted sample SHALL produce wr_en=1 the next cycle, with wr_data=s_data and wr_pixel=pixel count at acceptance (1-cycle latency).
REQ-011 Counters: data_cnt wraps at DATA_NUM-1 and increments pix_cnt; pix_cnt wraps at PIXEL_NUM-1 and increments acq_cnt; acq_cnt wraps at ACQ_NUM-1. Counters advance only on acceptance.
REQ-012 Acceptance with data_cnt=DATA_NUM-1, pix_cnt=PIXEL_NUM-1, acq_cnt=ACQ_NUM-1 is the last of the pass: all counters return to 0 and the state moves COARSE->PEAK_C or FINE->PEAK_F the next cycle, after which wr_en for that sample is emitted.
REQ-013 peak_req SHALL assert on the first PEAK_x cycle and stay high until peak_done; peak_done SHALL be ignored outside PEAK_x.
REQ-014 PEAK_C->CLR_F on peak_done; PEAK_F->DONE on peak_done.
REQ-015 DONE SHALL last one cycle with frame_done=1, then go to IDLE.
REQ-016 pass SHALL be 0 in CLR_C, COARSE, PEAK_C and 1 in CLR_F, FINE, PEAK_F, DONE; in IDLE it holds its last value.
REQ-017 abort in any non-IDLE state SHALL go to IDLE next cycle, zero all counters, drop clr_req/peak_req/s_ready, suppress pending wr_en, and give no frame_done; abort has priority over start, clr_done, peak_done.
REQ-018 clr_done together with abort SHALL be ignored (abort wins).
REQ-019 s_valid while s_ready=0 SHALL have no effect; s_data is not sampled.
REQ-020 Counter widths: data_cnt ceil(log2 DATA_NUM), pix_cnt 8, acq_cnt 20; no value beyond the terminal count.

Reset
REQ-021 On res high, immediately and for its duration: state IDLE, counters 0, pass 0, and s_ready, clr_req, wr_en, peak_req, busy, frame_done all 0; wr_data 0, wr_pixel 0.
REQ-022 Deassertion of res SHALL take effect on the next clk edge; a reset mid-pass discards the pass with no output pulses.

Verification (DATA_NUM=2, PIXEL_NUM=3, ACQ_NUM=2; 12 samples/pass)
REQ-023 start, clr_done at cycle 3, 12 continuous valid samples -> 12 wr_en pulses, wr_pixel 0,0,1,1,2,2,0,0,1,1,2,2, s_ready low after the 12th, peak_req high with pass=0.
REQ-024 Full frame with peak_done/clr_done answered after 2 cycles -> 24 wr_en in total, pass toggles 0->1 at CLR_F, exactly one frame_done, busy low afterward.
REQ-025 s_valid toggled every other cycle -> counters advance only on handshakes, wr_pixel sequence as in REQ-023.
REQ-026 abort after sample 7 of FINE -> IDLE next cycle, no further wr_en, no frame_done; subsequent start -> clean CLR_C with pass=0 and counters 0.
REQ-027 res asserted mid-COARSE asynchronously (between edges) -> outputs zero before the next edge; start while busy, and peak_done in COARSE -> no effect.
